// File: rtl/opl4_write_sequencer.sv
// Round-robin write sequencer for the YMF278B: two requesters post address/data pairs and
// the FSM plays them out as address phase, recovery gap, data phase, recovery gap.
module opl4_write_sequencer #(
    parameter int unsigned WR_PULSE = 3,
    parameter int unsigned ADDR_GAP = 4,
    parameter int unsigned DATA_GAP = 24
) (
    input  logic       msx_clk,
    input  logic       msx_reset_n,
    input  logic       req0_valid,
    input  logic [8:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [8:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       opl_cs_n,
    output logic       opl_wr_n,
    output logic       opl_a1,
    output logic       opl_a2,
    output logic [7:0] opl_d,
    output logic       opl_d_oe,
    output logic       busy
);

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, A_GAP, D_SETUP, D_PULSE, D_HOLD, D_GAP
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic [DW-1:0] data_q;
    logic          grant0;
    logic          grant1;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Fixed phase order; every non-IDLE state hands off to the next one when its count expires.
    function automatic state_t succ(input state_t s);
        case (s)
            A_SETUP: return A_PULSE;
            A_PULSE: return A_HOLD;
            A_HOLD:  return A_GAP;
            A_GAP:   return D_SETUP;
            D_SETUP: return D_PULSE;
            D_PULSE: return D_HOLD;
            D_HOLD:  return D_GAP;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [CW-1:0] load_of(input state_t s);
        case (s)
            IDLE:             return '0;
            A_PULSE, D_PULSE: return CW'(WR_PULSE);
            A_GAP:            return CW'(ADDR_GAP);
            D_GAP:            return CW'(DATA_GAP);
            default:          return CW'(1);
        endcase
    endfunction

    // Arbitration: the requester that did not win last time has priority under contention.
    always_comb begin
        grant0   = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
        grant1   = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
        nxt      = state;
        if (state == IDLE) begin
            if (grant0 || grant1) nxt = A_SETUP;
        end else if (cnt == CW'(1)) begin
            nxt = succ(state);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Bus pins are registered from the next state so they line up with the state they describe.
    always_ff @(posedge msx_clk) begin
        if (!msx_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            data_q     <= '0;
            opl_cs_n   <= 1'b1;
            opl_wr_n   <= 1'b1;
            opl_a1     <= 1'b0;
            opl_a2     <= 1'b0;
            opl_d      <= '0;
            opl_d_oe   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) cnt <= load_of(nxt);
            else if (cnt != '0) cnt <= cnt - CW'(1);

            if (grant0 || grant1) begin
                data_q     <= sel_data;
                last_grant <= grant1;
            end

            busy <= (nxt != IDLE);
            case (nxt)
                A_SETUP: begin
                    opl_cs_n <= 1'b0;
                    opl_wr_n <= 1'b1;
                    opl_a1   <= 1'b0;
                    opl_a2   <= sel_addr[8];
                    opl_d    <= sel_addr[7:0];
                    opl_d_oe <= 1'b1;
                end
                A_PULSE, D_PULSE: begin
                    opl_cs_n <= 1'b0;
                    opl_wr_n <= 1'b0;
                end
                A_HOLD, D_HOLD: begin
                    opl_wr_n <= 1'b1;
                end
                D_SETUP: begin
                    opl_cs_n <= 1'b0;
                    opl_wr_n <= 1'b1;
                    opl_a1   <= 1'b1;
                    opl_d    <= data_q;
                    opl_d_oe <= 1'b1;
                end
                default: begin
                    opl_cs_n <= 1'b1;
                    opl_wr_n <= 1'b1;
                    opl_d_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opl4_write_sequencer.sv
// Randomized scoreboard bench for opl4_write_sequencer: a phase-timeline model predicts grants
// and pin levels, and a bus monitor reassembles completed writes against the expected queue.
module tb_opl4_write_sequencer;

    localparam int P   = 3;
    localparam int AG  = 4;
    localparam int DG  = 24;
    localparam int B   = P + 2 + AG;
    localparam int WIN = 2 * (P + 2) + AG + DG;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [8:0] a0 = '0, a1_in = '0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       r0, r1, cs_n, wr_n, a1, a2, oe, busy;
    logic [7:0] d;

    logic       frst_n = 1'b0;
    logic       fv0 = 1'b0;
    logic [8:0] fa0 = '0;
    logic [7:0] fd0 = '0;
    logic       fr0, fr1, fcs_n, fwr_n, fa1, fa2, foe, fbusy;
    logic [7:0] fd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [16:0] expq[$];

    always #5 clk = ~clk;

    opl4_write_sequencer dut (
        .msx_clk(clk), .msx_reset_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
        .req1_valid(v1), .req1_addr(a1_in), .req1_data(d1), .req1_ready(r1),
        .opl_cs_n(cs_n), .opl_wr_n(wr_n), .opl_a1(a1), .opl_a2(a2),
        .opl_d(d), .opl_d_oe(oe), .busy(busy)
    );

    opl4_write_sequencer #(.WR_PULSE(1), .ADDR_GAP(1), .DATA_GAP(1)) dut_fast (
        .msx_clk(clk), .msx_reset_n(frst_n),
        .req0_valid(fv0), .req0_addr(fa0), .req0_data(fd0), .req0_ready(fr0),
        .req1_valid(1'b0), .req1_addr(9'h000), .req1_data(8'h00), .req1_ready(fr1),
        .opl_cs_n(fcs_n), .opl_wr_n(fwr_n), .opl_a1(fa1), .opl_a2(fa2),
        .opl_d(fd), .opl_d_oe(foe), .busy(fbusy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: k = cycles since the transfer edge (0 = idle); pins follow the phase timeline.
    int          k = 0;
    logic        last = 1'b1;
    logic        armed = 1'b0;
    logic        just_reset = 1'b0;
    logic        mhs0 = 1'b0, mhs1 = 1'b0;
    logic [8:0]  cur_a = '0;
    logic [7:0]  cur_d = '0;
    logic        prev_wr = 1'b1, prev_a1 = 1'b0;
    logic [7:0]  prev_d = '0;

    always @(negedge clk) begin
        logic in_a, in_d, e_cs, e_wr, e0, e1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (armed) begin
            in_a = (k >= 1) && (k <= P + 2);
            in_d = (k >= B + 1) && (k <= B + P + 2);
            e_cs = !(in_a || in_d);
            e_wr = !(((k >= 2) && (k <= P + 1)) || ((k >= B + 2) && (k <= B + P + 1)));
            chk("cs_n", cs_n, e_cs);
            chk("wr_n", wr_n, e_wr);
            chk("d_oe", oe, !e_cs);
            chk("busy", busy, k != 0);
            if (!e_cs) begin
                chk("a1", a1, in_d);
                chk("a2", a2, cur_a[8]);
                chk("d", d, in_a ? cur_a[7:0] : cur_d);
            end
            if (just_reset) begin
                chk("rst_a1", a1, 1'b0);
                chk("rst_a2", a2, 1'b0);
                chk("rst_d", d, 8'h00);
            end
            chk("inv_wr_in_cs", !wr_n && cs_n, 1'b0);
            if (!prev_wr && !wr_n) begin
                chk("stable_a1", a1, prev_a1);
                chk("stable_d", d, prev_d);
            end
        end
        prev_wr = wr_n;
        prev_a1 = a1;
        prev_d  = d;
        if (!rst_n) begin
            k = 0;
            last = 1'b1;
            expq.delete();
            armed = 1'b1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            e0 = (k == 0) && v0 && (!v1 || last);
            e1 = (k == 0) && v1 && (!v0 || !last);
            if (armed) begin
                chk("req0_ready", r0, e0);
                chk("req1_ready", r1, e1);
            end
            if (e0 || e1) begin
                k = 1;
                last = e1;
                cur_a = e1 ? a1_in : a0;
                cur_d = e1 ? d1 : d0;
                expq.push_back({cur_a, cur_d});
            end else if (k != 0) begin
                k = (k == WIN) ? 0 : k + 1;
            end
        end
        mhs0 = e0;
        mhs1 = e1;
    end

    // Bus monitor: assemble {a2, address byte, data byte} and retire it when the data strobe ends.
    logic [8:0] cap_a = '0;
    logic [7:0] cap_d = '0;
    logic       mon_prev_wr = 1'b1;
    always @(negedge clk) begin
        if (rst_n && armed) begin
            if (!wr_n && !a1) cap_a = {a2, d};
            if (!wr_n && a1) cap_d = d;
            if (wr_n && !mon_prev_wr && a1) begin
                if (expq.size() == 0) begin
                    chk("sb_unexpected_write", {15'd0, cap_a, cap_d}, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_write", {cap_a, cap_d}, expq.pop_front());
                end
            end
        end
        mon_prev_wr = wr_n;
    end

    // Requester drivers: payload stays put until the handshake retires it.
    always @(posedge clk) begin
        #1;
        if (mhs0 && q0.size() != 0) void'(q0.pop_front());
        if (mhs1 && q1.size() != 0) void'(q1.pop_front());
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        if (v0) {a0, d0} = q0[0];
        if (v1) {a1_in, d1} = q1[0];
    end

    // Minimum-timing instance: window length, idle gap and strobe nesting.
    int  f_run = 0, f_idle = 0;
    logic f_seen = 1'b0;
    always @(negedge clk) begin
        if (frst_n) begin
            chk("fast_inv_wr_in_cs", !fwr_n && fcs_n, 1'b0);
            chk("fast_oe", foe, !fcs_n);
            if (fbusy) begin
                if (f_seen && f_idle > 0) chk("fast_idle_gap", f_idle, 1);
                f_idle = 0;
                f_run++;
                f_seen = 1'b1;
            end else begin
                if (f_run > 0) chk("fast_busy_window", f_run, 8);
                f_run = 0;
                f_idle++;
            end
            if (fr0) begin
                fa0 <= 9'($urandom);
                fd0 <= 8'($urandom);
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || k != 0 || expq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < budget, 1'b1);
    endtask

    initial begin
        int n;
        logic [1:0] r;
        // Reset held 3 cycles with req0 already pending; it must win first after release.
        q0.push_back({9'h105, 8'hA5});
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        frst_n = 1'b1;
        fv0    = 1'b1;
        drain(200);

        // Contention: both queues loaded, grants must alternate.
        for (int i = 0; i < 4; i++) begin
            q0.push_back({9'($urandom), 8'($urandom)});
            q1.push_back({9'($urandom), 8'($urandom)});
        end
        drain(1000);

        // req1 arrives mid-transaction and must wait, payload untouched.
        @(posedge clk); #1;
        q0.push_back({9'h0_3C, 8'h5A});
        repeat (10) @(posedge clk);
        #1;
        q1.push_back({9'h1_F0, 8'hC3});
        drain(300);

        // Reset during the address write pulse aborts the transfer.
        @(posedge clk); #1;
        q0.push_back({9'h1_77, 8'h11});
        n = 0;
        while (k != 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_a_pulse", n < 50, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (45) @(posedge clk);
        drain(100);

        // Randomized traffic from both requesters.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            r = 2'($urandom_range(1, 3));
            if (r[0]) q0.push_back({9'($urandom), 8'($urandom)});
            if (r[1]) q1.push_back({9'($urandom), 8'($urandom)});
            repeat ($urandom_range(0, 50)) @(posedge clk);
        end
        drain(5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
